// File: rtl/mux_2to1_interleave.sv
// ---------------------------------------------------------------------------
// mux_2to1_interleave
//   Merges two half-rate lanes (lane 1 = even phase, lane 2 = odd phase) into
//   one full-rate signed sample stream. A pair is accepted on a one-cycle
//   strobe. Its two samples are then emitted on consecutive cycles.
//
// Parameters
//   BW          base width; sample width is BW+4 bits, signed
//   FIRST_LANE  1: emit IN1 then IN2; 2: emit IN2 then IN1
//
// Ports
//   CLK        in   full-rate clock, rising edge
//   RES        in   synchronous reset, active-high
//   IN1        in   lane-1 sample, signed
//   IN2        in   lane-2 sample, signed
//   IN_VALID   in   pair strobe; IN1/IN2 are sampled on the edge where it is high
//   OUT        out  interleaved sample, signed, registered
//   OUT_VALID  out  high in every cycle OUT carries a sample
//   OUT_PHASE  out  0: OUT is the first sample of its pair; 1: the second sample
//   ERR        out  sticky overrun flag, cleared only by RES
// ---------------------------------------------------------------------------
module mux_2to1_interleave #(
    parameter int unsigned BW         = 6,
    parameter int unsigned FIRST_LANE = 1
) (
    input  logic                 CLK,
    input  logic                 RES,
    input  logic signed [BW+3:0] IN1,
    input  logic signed [BW+3:0] IN2,
    input  logic                 IN_VALID,
    output logic signed [BW+3:0] OUT,
    output logic                 OUT_VALID,
    output logic                 OUT_PHASE,
    output logic                 ERR
);

    localparam int unsigned SW = BW + 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        EMIT1 = 2'd1,
        EMIT2 = 2'd2
    } state_t;

    state_t               state;
    state_t               state_n;
    logic signed [SW-1:0] hold2;
    logic signed [SW-1:0] hold2_n;
    logic signed [SW-1:0] out_n;
    logic                 out_valid_n;
    logic                 out_phase_n;
    logic                 err_n;

    // Pair split into emit order; the first sample goes straight to OUT,
    // so only the second one needs a holding register.
    logic signed [SW-1:0] first_c;
    logic signed [SW-1:0] second_c;

    assign first_c  = (FIRST_LANE == 2) ? IN2 : IN1;
    assign second_c = (FIRST_LANE == 2) ? IN1 : IN2;

    // State and output registers
    always_ff @(posedge CLK) begin
        if (RES) begin
            state     <= IDLE;
            hold2     <= '0;
            OUT       <= '0;
            OUT_VALID <= 1'b0;
            OUT_PHASE <= 1'b0;
            ERR       <= 1'b0;
        end else begin
            state     <= state_n;
            hold2     <= hold2_n;
            OUT       <= out_n;
            OUT_VALID <= out_valid_n;
            OUT_PHASE <= out_phase_n;
            ERR       <= err_n;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_n     = state;
        hold2_n     = hold2;
        out_n       = OUT;
        out_valid_n = 1'b0;
        out_phase_n = 1'b0;
        err_n       = ERR;

        case (state)
            IDLE: begin
                if (IN_VALID) begin
                    hold2_n     = second_c;
                    out_n       = first_c;
                    out_valid_n = 1'b1;
                    out_phase_n = 1'b0;
                    state_n     = EMIT1;
                end
            end

            EMIT1: begin
                // A strobe here arrives before the held sample is out: drop it.
                out_n       = hold2;
                out_valid_n = 1'b1;
                out_phase_n = 1'b1;
                state_n     = EMIT2;
                if (IN_VALID) begin
                    err_n = 1'b1;
                end
            end

            EMIT2: begin
                // Back-to-back pair keeps the stream gapless.
                if (IN_VALID) begin
                    hold2_n     = second_c;
                    out_n       = first_c;
                    out_valid_n = 1'b1;
                    out_phase_n = 1'b0;
                    state_n     = EMIT1;
                end else begin
                    state_n = IDLE;
                end
            end

            default: begin
                state_n = IDLE;
            end
        endcase
    end

endmodule
